spi_master_sched: RTL and testbench

- Master-side SPI transfer scheduler: shares one SPI bus (sclk, mosi, miso, cs_n) between NUM_REQ on-chip requesters.
- Round-robin arbiter selects a requester, then a sequencer drives one full-duplex mode-0 frame to the addressed slave and returns the MISO byte.
- Sits between test/stimulus requesters and the SPI interface signals, opposite the slave agent BFM.

---
 rtl/spi_master_sched_if.sv | 31 +++
 rtl/spi_master_sched.sv | 189 ++++++++++++++++++
 tb/tb_spi_master_sched.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_sched_if.sv
// Bundle of the requester handshake and SPI bus signals of spi_master_sched.
// The master modport is the scheduler's view; the slave modport is the view
// of whatever sits opposite it (requesters and the SPI slave agent).
interface spi_master_sched_if #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int NO_OF_SLAVES = 4,
    parameter int CS_W         = 2
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ*CS_W-1:0]       req_cs;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic [DATA_WIDTH-1:0]         rx_data;
    logic                          busy;
    logic                          sclk;
    logic [NO_OF_SLAVES-1:0]       cs_n;
    logic                          mosi;
    logic                          miso;

    modport master (
        input  req, req_data, req_cs, miso,
        output gnt, done, rx_data, busy, sclk, cs_n, mosi
    );

    modport slave (
        output req, req_data, req_cs, miso,
        input  gnt, done, rx_data, busy, sclk, cs_n, mosi
    );
endinterface

// File: rtl/spi_master_sched.sv
// SPI master transfer scheduler: round-robin arbitration between NUM_REQ
// requesters, then one full-duplex SPI mode-0 frame to the selected slave.
// Optional feature macro SPI_MASTER_SCHED_PRIORITY_EN: requester 0 becomes
// strict high priority and the rest round-robin among themselves.
module spi_master_sched #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int NO_OF_SLAVES = 4,
    parameter int CS_W         = 2,
    parameter int CLK_DIV      = 2
) (
    input logic                 pclk,
    input logic                 areset,
    spi_master_sched_if.master  bus
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_N = 2 * DATA_WIDTH;
    localparam int EDGE_W = $clog2(EDGE_N);

`ifdef SPI_MASTER_SCHED_PRIORITY_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [IDX_W-1:0]       r_last;
    logic [IDX_W-1:0]       r_owner;
    logic [CS_W-1:0]        r_idx;
    logic [DIV_W-1:0]       r_div;
    logic [EDGE_W-1:0]      r_edge;
    logic                   r_sclk;
    logic [DATA_WIDTH-1:0]  r_tx;
    logic [DATA_WIDTH-1:0]  r_rx;
    logic [DATA_WIDTH-1:0]  r_rx_data;

    logic                   w_win_valid;
    logic [IDX_W-1:0]       w_winner;
    logic                   w_upd_last;
    logic                   w_grant;
    logic                   w_div_end;
    logic                   w_last_edge;

    assign w_div_end   = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last_edge = (r_edge == EDGE_W'(EDGE_N - 1));
    // A grant is never issued while reset is asserted.
    assign w_grant     = (r_state == S_IDLE) && w_win_valid && !areset;

    // Arbiter: first pending request after the pointer, wrapping around;
    // the loop runs from the farthest candidate so the nearest one wins.
    always_comb begin
        w_win_valid = 1'b0;
        w_winner    = '0;
        w_upd_last  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req[(int'(r_last) + k) % NUM_REQ] &&
                (!PRIO_EN || ((int'(r_last) + k) % NUM_REQ) != 0)) begin
                w_win_valid = 1'b1;
                w_winner    = IDX_W'((int'(r_last) + k) % NUM_REQ);
                w_upd_last  = 1'b1;
            end
        end
        // Requester 0 overrides the rotation and leaves the pointer alone.
        if (PRIO_EN && bus.req[0]) begin
            w_win_valid = 1'b1;
            w_winner    = '0;
            w_upd_last  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge pclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; every non-idle phase lasts whole CLK_DIV periods.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_SETUP;
            S_SETUP: if (w_div_end) w_next = S_SHIFT;
            S_SHIFT: if (w_div_end && w_last_edge) w_next = S_HOLD;
            S_HOLD:  if (w_div_end) w_next = S_GAP;
            S_GAP:   if (w_div_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Control registers: pointer, phase divider, sclk generator, rx output.
    always_ff @(posedge pclk) begin
        if (areset) begin
            r_last    <= IDX_W'(NUM_REQ - 1);
            r_div     <= '0;
            r_edge    <= '0;
            r_sclk    <= 1'b0;
            r_rx_data <= '0;
        end else begin
            if (r_state == S_IDLE || w_div_end) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_grant && w_upd_last) begin
                r_last <= w_winner;
            end

            // 2*DATA_WIDTH toggles starting low->high leave sclk low at the end.
            if (r_state == S_SHIFT) begin
                if (w_div_end) begin
                    r_sclk <= ~r_sclk;
                    r_edge <= r_edge + 1'b1;
                end
            end else begin
                r_sclk <= 1'b0;
                r_edge <= '0;
            end

            if (r_state == S_HOLD && w_div_end) begin
                r_rx_data <= r_rx;
            end
        end
    end

    // Frame data: latch the winner's word and slave index, then shift.
    always_ff @(posedge pclk) begin
        if (w_grant) begin
            r_tx    <= bus.req_data[w_winner*DATA_WIDTH +: DATA_WIDTH];
            r_idx   <= bus.req_cs[w_winner*CS_W +: CS_W];
            r_owner <= w_winner;
        end else if (r_state == S_SHIFT && w_div_end) begin
            if (!r_sclk) begin
                // sclk about to rise: capture miso
                r_rx <= {r_rx[DATA_WIDTH-2:0], bus.miso};
            end else if (!w_last_edge) begin
                // sclk about to fall: present next tx bit (not after the last bit)
                r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    // Outputs decoded from state and registers.
    always_comb begin
        bus.gnt     = '0;
        bus.done    = '0;
        bus.busy    = (r_state != S_IDLE);
        bus.sclk    = r_sclk;
        bus.cs_n    = '1;
        bus.mosi    = 1'b0;
        bus.rx_data = r_rx_data;
        if (w_grant) begin
            bus.gnt[w_winner] = 1'b1;
        end
        case (r_state)
            S_SETUP, S_SHIFT, S_HOLD: begin
                bus.mosi = r_tx[DATA_WIDTH-1];
                // An out-of-range index simply matches no line.
                for (int s = 0; s < NO_OF_SLAVES; s++) begin
                    if (int'(r_idx) == s) begin
                        bus.cs_n[s] = 1'b0;
                    end
                end
            end
            S_GAP: begin
                if (r_div == '0) begin
                    bus.done[r_owner] = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_master_sched.sv
// Self-checking bench for spi_master_sched with a frame-level reference model.
module tb_spi_master_sched;

    localparam int NR     = 4;
    localparam int DW     = 8;
    localparam int NS     = 3;
    localparam int CSW    = 2;
    localparam int CD     = 2;
    localparam int FRAME  = (2*DW + 3) * CD;
    localparam int CS_LOW = (2*DW + 2) * CD;

    logic pclk;
    logic areset;

    int n_chk  = 0;
    int n_fail = 0;
    int m_last = NR - 1;
    int m_rx   = 0;

    spi_master_sched_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .NO_OF_SLAVES(NS), .CS_W(CSW)) bus ();

    spi_master_sched #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .NO_OF_SLAVES(NS), .CS_W(CSW), .CLK_DIV(CD)
    ) dut (
        .pclk   (pclk),
        .areset (areset),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: first pending requester after the last winner.
    function automatic int model_winner(input logic [NR-1:0] rv);
`ifdef SPI_MASTER_SCHED_PRIORITY_EN
        if (rv[0]) return 0;
`endif
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (m_last + k) % NR;
`ifdef SPI_MASTER_SCHED_PRIORITY_EN
            if (c == 0) continue;
`endif
            if (rv[c]) return c;
        end
        return -1;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.req      = '0;
            bus.req_data = {$urandom, $urandom};
            bus.req_cs   = NR*CSW'($urandom);
            #1;
            chk("idle_gnt", bus.gnt, 0);
            chk("idle_busy", bus.busy, 0);
            chk("idle_cs_n", bus.cs_n, {NS{1'b1}});
            chk("idle_sclk", bus.sclk, 0);
            chk("idle_done", bus.done, 0);
            chk("idle_rx_hold", bus.rx_data, m_rx);
            cyc();
        end
    endtask

    // One arbitration plus the whole frame that follows it, checked cycle by
    // cycle against the timing rules. Negative force values mean random.
    task automatic frame(input logic [NR-1:0] rv, input int fcs, input int ftx,
                         input int fmiso, input int abort_at);
        int w, cs, tx_w, rx_w, p, rises, exp_sclk, bidx;
        logic [NR*DW-1:0]  dv;
        logic [NR*CSW-1:0] cv;
        logic [NS-1:0]     mask;
        for (int i = 0; i < NR; i++) begin
            dv[i*DW +: DW]   = DW'($urandom);
            cv[i*CSW +: CSW] = CSW'($urandom_range(0, 3));
        end
        w = model_winner(rv);
        if (ftx >= 0) dv[w*DW +: DW] = DW'(ftx);
        if (fcs >= 0) cv[w*CSW +: CSW] = CSW'(fcs);
        rx_w = (fmiso >= 0) ? fmiso : int'($urandom_range(0, 255));
        tx_w = int'(dv[w*DW +: DW]);
        cs   = int'(cv[w*CSW +: CSW]);
        bus.req      = rv;
        bus.req_data = dv;
        bus.req_cs   = cv;
        bus.miso     = 1'b0;
        #1;
        chk("gnt", bus.gnt, 64'(1) << w);
        chk("busy_at_gnt", bus.busy, 0);
`ifdef SPI_MASTER_SCHED_PRIORITY_EN
        if (w != 0) m_last = w;
`else
        m_last = w;
`endif
        mask = '1;
        if (cs < NS) mask[cs] = 1'b0;
        cyc();
        for (int c = 1; c <= FRAME; c++) begin
            p        = c - 1 - CD;
            exp_sclk = (p >= 0 && p < 2*DW*CD) ? ((p / CD) % 2) : 0;
            rises    = (p < 0) ? 0 : (p + CD) / (2*CD);
            if (rises > DW-1) rises = DW-1;
            bus.miso     = 1'((rx_w >> (DW-1-rises)) & 1);
            bus.req      = NR'($urandom);
            bus.req_data = {$urandom, $urandom};
            bus.req_cs   = NR*CSW'($urandom);
            if (c == abort_at) areset = 1'b1;
            #1;
            chk("gnt_in_frame", bus.gnt, 0);
            chk("busy", bus.busy, 1);
            chk("cs_n", bus.cs_n, (c <= CS_LOW) ? mask : {NS{1'b1}});
            chk("sclk", bus.sclk, exp_sclk);
            chk("done", bus.done, (c == CS_LOW + 1) ? (64'(1) << w) : 64'(0));
            if (c == CS_LOW + 1) begin
                chk("rx_data", bus.rx_data, rx_w);
                m_rx = rx_w;
            end
            if (exp_sclk == 1) begin
                bidx = p / (2*CD);
                chk("mosi", bus.mosi, (tx_w >> (DW-1-bidx)) & 1);
            end
            cyc();
            if (c == abort_at) begin
                areset  = 1'b0;
                bus.req = '0;
                #1;
                chk("abort_cs_n", bus.cs_n, {NS{1'b1}});
                chk("abort_sclk", bus.sclk, 0);
                chk("abort_busy", bus.busy, 0);
                chk("abort_done", bus.done, 0);
                chk("abort_gnt", bus.gnt, 0);
                chk("abort_mosi", bus.mosi, 0);
                chk("abort_rx", bus.rx_data, 0);
                m_last = NR - 1;
                m_rx   = 0;
                cyc();
                return;
            end
        end
        bus.req = '0;
    endtask

    initial begin
        areset       = 1'b1;
        bus.req      = '1;
        bus.req_data = '0;
        bus.req_cs   = '0;
        bus.miso     = 1'b0;
        cyc();
        cyc();
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rx", bus.rx_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_cs_n", bus.cs_n, {NS{1'b1}});
        chk("rst_mosi", bus.mosi, 0);
        areset  = 1'b0;
        bus.req = '0;
        cyc();
        idle(2);

        // Single transfer to slave 2.
        frame(4'b0010, 2, 8'hA5, 8'h3C, 0);
        idle(1);

        // Reset in the middle of a frame, then a fresh full request set.
        frame(4'b0010, -1, -1, -1, 1 + 10*CD);
        idle(1);

        // Fairness with every request held across back-to-back frames.
        for (int i = 0; i < 5; i++) frame(4'b1111, -1, -1, -1, 0);

        // Late arrival: req[2] appears during requester 0's frame.
        frame(4'b0001, -1, -1, -1, 0);
        frame(4'b0101, -1, -1, -1, 0);

        // Out-of-range slave index drives no chip select.
        frame(4'b1000, 3, -1, -1, 0);
        idle(2);

`ifdef SPI_MASTER_SCHED_PRIORITY_EN
        for (int i = 0; i < 3; i++) frame(4'b1001, -1, -1, -1, 0);
        frame(4'b1000, -1, -1, -1, 0);
`endif

        // Random traffic.
        for (int i = 0; i < 12; i++) begin
            idle($urandom_range(0, 3));
            frame(NR'($urandom_range(1, (1 << NR) - 1)), -1, -1, -1, 0);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
